// File: rtl/pe_chain_ctrl_pkg.sv
// rtl/pe_chain_ctrl_pkg.sv - shared types, constants and width helpers for the PE chain controller
package pe_chain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_ABORT
  } state_e;

  // Cycles from the last accepted pixel until its result has been issued.
  localparam int DRAIN_CYCLES = 3;

  localparam int ERR_SHORT_ROW = 0;
  localparam int ERR_W_WR_BUSY = 1;
  localparam int ERR_UNDERRUN  = 2;
  localparam int ERR_PE_DONE   = 3;
  localparam int ERR_NUM       = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sum_width(input int dw, input int ww, input int n);
    return dw + ww + clog2(n);
  endfunction

endpackage

// File: rtl/pe_sum_tree.sv
// rtl/pe_sum_tree.sv - registered zero-extending adder of N PE products, one cycle latency
module pe_sum_tree #(
  parameter int N  = 3,
  parameter int PW = 16,
  parameter int SW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*PW-1:0] prod_i,
  output logic [SW-1:0]   sum_o
);

  logic [SW-1:0] sum_d, sum_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + SW'(prod_i[i*PW +: PW]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/pe_chain_ctrl.sv
// rtl/pe_chain_ctrl.sv - sequencer for a linear PE chain forming a 1-D FIR row filter
module pe_chain_ctrl
  import pe_chain_ctrl_pkg::*;
#(
  parameter int  NUM_PE       = 3,
  parameter int  DATA_WIDTH   = 8,
  parameter int  WEIGHT_WIDTH = 8,
  parameter int  LEN_WIDTH    = 12,
  localparam int AW           = clog2(NUM_PE),
  localparam int PW           = DATA_WIDTH + WEIGHT_WIDTH,
  localparam int SUM_WIDTH    = sum_width(DATA_WIDTH, WEIGHT_WIDTH, NUM_PE)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_wr,
  input  logic [AW-1:0]                  w_addr,
  input  logic [WEIGHT_WIDTH-1:0]        w_data,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           row_len,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          pe_input,
  output logic [NUM_PE*WEIGHT_WIDTH-1:0] pe_weight,
  output logic [NUM_PE-1:0]              pe_en,
  input  logic [NUM_PE*PW-1:0]           pe_output,
  input  logic [NUM_PE-1:0]              pe_done,
  output logic                           out_valid,
  output logic [SUM_WIDTH-1:0]           out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           row_done,
  output logic                           err
);

  localparam int TW = clog2(NUM_PE + 3);

  state_e                                state_q, state_d;
  logic [NUM_PE-1:0][WEIGHT_WIDTH-1:0]   w_q;
  logic [LEN_WIDTH-1:0]                  len_q, len_d, cnt_q, cnt_d;
  logic [TW-1:0]                         tmr_q, tmr_d;
  logic [NUM_PE-1:1]                     en_sr_q;
  logic                                  v1_q, v2_q, l1_q, l2_q;
  logic                                  out_valid_q, out_last_q, row_done_q, row_done_d, err_q, err_d;
  logic                                  accept, start_ok, sched;
  logic [ERR_NUM-1:0]                    err_src;
  logic [SUM_WIDTH-1:0]                  sum;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    row_done_d = 1'b0;
    accept     = 1'b0;
    start_ok   = 1'b0;
    err_src    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (row_len >= LEN_WIDTH'(NUM_PE)) begin
            state_d  = ST_STREAM;
            len_d    = row_len;
            cnt_d    = '0;
            start_ok = 1'b1;
          end else begin
            err_src[ERR_SHORT_ROW] = 1'b1;
            row_done_d             = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        // The chain forwards every cycle, so a missing pixel cannot be absorbed.
        if (in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = ST_DRAIN;
            tmr_d   = TW'(DRAIN_CYCLES - 1);
          end
        end else begin
          state_d               = ST_ABORT;
          tmr_d                 = TW'(NUM_PE + 1);
          err_src[ERR_UNDERRUN] = 1'b1;
        end
      end
      ST_DRAIN, ST_ABORT: begin
        if (tmr_q == '0) begin
          state_d    = ST_IDLE;
          row_done_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sched                  = v2_q && (state_d != ST_ABORT);
    err_src[ERR_W_WR_BUSY] = w_wr && (state_q != ST_IDLE);
    err_src[ERR_PE_DONE]   = sched && !(&pe_done);
    err_d                  = (start_ok ? 1'b0 : err_q) | (|err_src);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      w_q         <= '0;
      en_sr_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      l1_q        <= 1'b0;
      l2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      row_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      row_done_q <= row_done_d;
      err_q      <= err_d;
      if (w_wr && (state_q == ST_IDLE) && (32'(w_addr) < NUM_PE)) begin
        w_q[w_addr] <= w_data;
      end
      en_sr_q[1] <= accept;
      for (int i = 2; i < NUM_PE; i++) begin
        en_sr_q[i] <= en_sr_q[i-1];
      end
      // Result tag pipeline: products for an accepted pixel land two cycles later.
      v1_q        <= accept && (cnt_q >= LEN_WIDTH'(NUM_PE - 1));
      l1_q        <= accept && (cnt_q == len_q - 1'b1);
      v2_q        <= v1_q && (state_d != ST_ABORT);
      l2_q        <= l1_q;
      out_valid_q <= sched;
      out_last_q  <= l2_q && sched;
    end
  end

  pe_sum_tree #(
    .N  (NUM_PE),
    .PW (PW),
    .SW (SUM_WIDTH)
  ) u_sum (
    .clk    (clk),
    .rst    (rst),
    .prod_i (pe_output),
    .sum_o  (sum)
  );

  assign in_ready  = (state_q == ST_STREAM);
  assign pe_input  = accept ? in_data : '0;
  assign pe_en     = {en_sr_q, accept};
  assign pe_weight = w_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? sum : '0;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign row_done  = row_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// tb/tb_pe_chain_ctrl.sv - scoreboard bench for pe_chain_ctrl with a behavioural PE chain and FIR reference
module tb_pe_chain_ctrl;

  localparam int K  = 3;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int LW = 12;
  localparam int PW = DW + WW;
  localparam int SW = 18;
  localparam int AW = 2;

  logic              clk, rst, w_wr, start, in_valid, in_ready;
  logic              out_valid, out_last, busy, row_done, err;
  logic [AW-1:0]     w_addr;
  logic [WW-1:0]     w_data;
  logic [LW-1:0]     row_len;
  logic [DW-1:0]     in_data, pe_input;
  logic [K*WW-1:0]   pe_weight;
  logic [K-1:0]      pe_en, pe_done;
  logic [K*PW-1:0]   pe_output;
  logic [SW-1:0]     out_data;

  typedef struct { int data; bit last; int cyc; } res_t;
  typedef struct { int cyc; bit err; } rd_t;

  res_t res_q[$];
  rd_t  rd_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   err_m = 0;
  bit   done_low = 0;
  int   w_ref[K];

  pe_chain_ctrl dut (
    .clk(clk), .rst(rst), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
    .start(start), .row_len(row_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .pe_input(pe_input), .pe_weight(pe_weight), .pe_en(pe_en),
    .pe_output(pe_output), .pe_done(pe_done), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .row_done(row_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // PE chain: each PE forwards its pixel one cycle down the chain; product lands two cycles later.
  logic [DW-1:0] pin [K];
  logic [DW-1:0] xf  [K];
  logic [PW-1:0] p1  [K];
  logic [PW-1:0] p2  [K];

  always_comb begin
    pin[0] = pe_input;
    for (int i = 1; i < K; i++) pin[i] = xf[i-1];
  end

  always_comb begin
    pe_output = '0;
    for (int i = 0; i < K; i++) pe_output[i*PW +: PW] = p2[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        xf[i] <= '0;
        p1[i] <= '0;
        p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        xf[i] <= pin[i];
        p1[i] <= pe_en[i] ? PW'(pe_weight[i*WW +: WW]) * PW'(pin[i]) : '0;
        p2[i] <= p1[i];
      end
    end
  end

  assign pe_done = done_low ? '0 : '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    res_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (res_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 0);
          end else begin
            e = res_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
            check("out_cycle", cyc, e.cyc);
          end
        end
        if (row_done) begin
          if (rd_q.size() == 0) begin
            check("unexpected_row_done", row_done, 0);
          end else begin
            r = rd_q.pop_front();
            check("row_done_cycle", cyc, r.cyc);
            check("err_at_row_done", err, r.err);
          end
        end
      end
    end
  endtask

  task automatic wr_w(input int addr, input int data);
    w_wr   = 1'b1;
    w_addr = addr[AW-1:0];
    w_data = data[WW-1:0];
    tick();
    w_wr = 1'b0;
    w_ref[addr] = data;
  endtask

  // pix_mode: 0 random, 1 sequence 1,2,3..., 2 all 255. abort_p < 0 means no underrun.
  task automatic run_row(input int len, input int abort_p, input bit wr_mid, input bit b2b, input int pix_mode);
    int s, c, rd, y;
    int x[$];
    s       = cyc;
    start   = 1'b1;
    row_len = len[LW-1:0];
    tick();
    start = 1'b0;
    if (len < K) begin
      err_m = 1'b1;
      rd    = s + 1;
      rd_q.push_back('{rd, 1'b1});
      check("reject_busy", busy, 0);
      check("reject_in_ready", in_ready, 0);
    end else begin
      err_m = done_low;
      check("err_cleared_by_start", err, 0);
      rd = s + len + 4;
      for (int n = 0; n < len; n++) begin
        c = cyc;
        if (n == abort_p) begin
          in_valid = 1'b0;
          err_m    = 1'b1;
          rd       = c + K + 3;
          tick();
          break;
        end
        case (pix_mode)
          1:       x.push_back(n + 1);
          2:       x.push_back(255);
          default: x.push_back($urandom_range(0, 255));
        endcase
        in_valid = 1'b1;
        in_data  = x[n][DW-1:0];
        if (wr_mid && n == 1) begin
          w_wr   = 1'b1;
          w_addr = '0;
          w_data = WW'($urandom);
          err_m  = 1'b1;
        end
        check("in_ready_stream", in_ready, 1);
        if (n >= K - 1 && (abort_p < 0 || n <= abort_p - 3)) begin
          y = 0;
          for (int i = 0; i < K; i++) y += w_ref[i] * x[n-i];
          res_q.push_back('{y, n == len - 1, c + 3});
        end
        tick();
        w_wr = 1'b0;
      end
      in_valid = 1'b0;
      in_data  = '0;
      rd_q.push_back('{rd, err_m});
    end
    while (cyc < rd + (b2b ? 0 : 2)) tick();
  endtask

  initial begin
    bit b2b, prev_b2b;
    int kind, len;
    rst = 1'b1; w_wr = 1'b0; w_addr = '0; w_data = '0; start = 1'b0;
    row_len = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < K; i++) w_ref[i] = 0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("reset_outputs", {in_ready, busy, pe_en, pe_input, pe_weight, out_valid,
                            out_data, out_last, row_done, err}, 0);
    rst = 1'b0;
    tick();

    wr_w(0, 1); wr_w(1, 2); wr_w(2, 3);
    run_row(5, -1, 0, 0, 1);

    wr_w(0, 255); wr_w(1, 255); wr_w(2, 255);
    run_row(3, -1, 0, 0, 2);

    run_row(2, -1, 0, 0, 0);

    wr_w(0, 1); wr_w(1, 2); wr_w(2, 3);
    run_row(6, 3, 0, 0, 1);
    run_row(5, -1, 0, 0, 1);

    run_row(5, -1, 1, 0, 1);
    check("weights_kept", pe_weight, {8'd3, 8'd2, 8'd1});

    done_low = 1'b1;
    run_row(4, -1, 0, 0, 0);
    done_low = 1'b0;

    start = 1'b1; row_len = 12'd6; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'd7; tick();
    in_data = 8'd9; tick();
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {in_ready, busy, pe_en, pe_input, pe_weight, out_valid,
                              out_data, out_last, row_done, err}, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < K; i++) w_ref[i] = 0;
    tick();
    wr_w(0, 1); wr_w(1, 2); wr_w(2, 3);
    run_row(5, -1, 0, 0, 1);

    prev_b2b = 1'b0;
    for (int r = 0; r < 30; r++) begin
      b2b = (r != 29) && ($urandom_range(0, 2) == 0);
      if (!prev_b2b && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < K; i++) wr_w(i, $urandom_range(0, 255));
      end
      kind = $urandom_range(0, 9);
      len  = $urandom_range(K, 16);
      if (kind == 0)      run_row($urandom_range(0, K - 1), -1, 0, b2b, 0);
      else if (kind <= 2) run_row(len, $urandom_range(0, len - 1), 0, b2b, 0);
      else                run_row(len, -1, 0, b2b, 0);
      prev_b2b = b2b;
    end

    repeat (10) tick();
    check("results_pending", res_q.size(), 0);
    check("row_done_pending", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_chain_ctrl.md
Name: pe_chain_ctrl

Overview:
- Sequencer for a linear chain of NUM_PE pe instances that together form a 1-D FIR / inflation row filter.
- Owns the tap weights, streams pixels into PE0 and staggers the per-PE enables to match the pixel forwarding chain.
- Sums the PE products into one filtered output per pixel and reports row completion and errors to the layer scheduler.

Parameters:
- NUM_PE, 3: number of PEs and taps (K); must be at least 2.
- DATA_WIDTH, 8: pixel width.
- WEIGHT_WIDTH, 8: weight width.
- LEN_WIDTH, 12: width of the row length field.
- SUM_WIDTH (localparam): DATA_WIDTH+WEIGHT_WIDTH+clog2(NUM_PE), 18 at defaults.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- w_wr  in  1  weight write strobe.
- w_addr  in  clog2(NUM_PE)  tap index.
- w_data  in  WEIGHT_WIDTH  weight value.
- start  in  1  start a row; single-cycle pulse.
- row_len  in  LEN_WIDTH  pixel count, sampled on start.
- in_valid  in  1  pixel valid.
- in_data  in  DATA_WIDTH  pixel.
- in_ready  out  1  controller accepts a pixel this cycle.
- pe_input  out  DATA_WIDTH  pixel to PE0.
- pe_weight  out  NUM_PE*WEIGHT_WIDTH  tap i drives slice i.
- pe_en  out  NUM_PE  per-PE enable.
- pe_output  in  NUM_PE*(DATA_WIDTH+WEIGHT_WIDTH)  per-PE products.
- pe_done  in  NUM_PE  per-PE done.
- out_valid  out  1  filtered result valid (no backpressure).
- out_data  out  SUM_WIDTH  filtered result, unsigned.
- out_last  out  1  last result of the row.
- busy  out  1  state is not IDLE.
- row_done  out  1  one-cycle pulse at end of a row or an abort.
- err  out  1  sticky error flag; cleared by an accepted start.

Behaviour:
- Reset (async, rst=1) clears all outputs, weight registers, counters and the enable shift register to 0, and sets state to IDLE. Reset asserted mid-row abandons the row with no row_done.
- Weights: a write (w_wr) in IDLE loads tap w_addr on the next edge. A write while busy is ignored and sets err. pe_weight is driven directly from the weight registers and stays stable during a row.
- FSM states are IDLE, STREAM, DRAIN and ABORT.
- IDLE to STREAM on start when row_len >= NUM_PE. A start with row_len < NUM_PE is rejected: err is set, row_done pulses next cycle, and the FSM stays in IDLE. A start while busy is ignored with no error.
- STREAM:
  - in_ready = 1. An accept is in_valid & in_ready.
  - pe_input = in_data on accept, else 0.
  - pe_en[0] = accept; pe_en[i] = pe_en[0] delayed by i cycles through the registered shift chain, tracking the pixel forwarding of one cycle per PE.
  - After row_len accepts, go to DRAIN.
  - If in_valid = 0 in any STREAM cycle, the chain cannot stall, so go to ABORT and set err.
- DRAIN: in_ready = 0. Wait until the last result has been issued (3 cycles), then pulse row_done and return to IDLE.
- ABORT: in_ready = 0 and pe_en[0] = 0. Flush NUM_PE+2 cycles and suppress out_valid. Then pulse row_done and return to IDLE.
- Result timing:
  - For pixel n accepted in cycle c, all PE products for y[n] = sum over i of w[i]*x[n-i] are present at cycle c+2.
  - The controller registers the zero-extended sum, giving out_valid/out_data in cycle c+3.
  - out_valid is issued only for n >= NUM_PE-1, so a row yields row_len-NUM_PE+1 results. out_last accompanies n = row_len-1.
- Sanity check: whenever out_valid is scheduled but &pe_done is 0, set err (the result is still issued).
- Arithmetic is unsigned and the sum cannot overflow SUM_WIDTH.
- A start accepted in the same cycle as a row_done pulse is legal, but row_done pulses only when the FSM is in IDLE.

Decomposition:
- Shared package: FSM state encoding, SUM_WIDTH and clog2 helper, error cause constants.
- One sub-module, pe_sum_tree: a registered adder of NUM_PE products, one cycle latency.

Test Plan:
- Weights 1,2,3; row_len 5; pixels 1..5 contiguous -> out_data 10,16,22 on three consecutive cycles. First out_valid 3 cycles after pixel 3 is accepted. out_last on 22. row_done follows, err = 0.
- All weights 255 and pixels 255, row_len 3 -> a single result of 195075 with no truncation.
- row_len 2 -> no pixels accepted, err = 1, row_done pulses once, busy stays 0.
- in_valid drops after pixel 3 of 6 -> ABORT, no further out_valid, err = 1, row_done after the flush. A following start clears err.
- w_wr during STREAM -> weights unchanged, outputs match the first scenario, err = 1.
- rst asserted mid-STREAM -> all outputs 0 immediately. A new row then runs correctly with the weights re-written.
